// File: rtl/rnbip_stack_pkg.sv
// Shared definitions for the stack sequencer.
//   - OP_PUSH / OP_CALL / OP_POP / OP_RET : req_op encodings
//   - ST_IDLE / ST_POP_RD                 : sequencer state encodings
//   - DEF_STACK_BASE / DEF_STACK_LIMIT    : default stack window
package rnbip_stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_CALL = 2'b01,
    OP_POP  = 2'b10,
    OP_RET  = 2'b11
  } stack_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_POP_RD = 1'b1
  } stack_state_e;

  localparam logic [7:0] DEF_STACK_BASE  = 8'hFF;
  localparam logic [7:0] DEF_STACK_LIMIT = 8'hC0;

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer in front of the data memory. Owns the stack pointer and
// steers the memory address/data muxes for PUSH, CALL, POP and RET. Pop data
// is captured from the memory's combinational read port and returned with a
// one-cycle valid pulse. The stack grows downward; SP points at the next free
// location.
//
// Optional feature macro: STACK_GUARD_EN
//   defined   : pushes below STACK_LIMIT and pops at STACK_BASE are refused
//               and flagged in sticky ovf_err / unf_err.
//   undefined : no checks, SP wraps modulo 256, ovf_err/unf_err tied to 0,
//               and the STACK_LIMIT parameter does not exist.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid, req_op   request handshake and operation code
//   req_ready           request can be accepted (IDLE and not in reset)
//   mem_rdata           memory read data at the selected address
//   sp_out              stack pointer, memory SP address input
//   mem_wr              memory write strobe
//   sel_sp              address select, 1 = SP, 0 = R0
//   sel_rn              write-data select, 1 = R_N (PUSH), 0 = NPC (CALL)
//   rsp_valid           one-cycle pulse, rsp_data valid
//   rsp_data            popped byte, held until the next pop
//   rsp_is_ret          response belongs to a RET (1) or a POP (0)
//   sp_empty            sp_out == STACK_BASE
//   ovf_err, unf_err    sticky overflow / underflow flags
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | accepting requests; PUSH/CALL complete here in one cycle
// ST_POP_RD | SP already incremented, memory read at SP is captured
module stack_ctrl
  import rnbip_stack_pkg::*;
#(
`ifdef STACK_GUARD_EN
  parameter logic [7:0] STACK_LIMIT = DEF_STACK_LIMIT,
`endif
  parameter logic [7:0] STACK_BASE  = DEF_STACK_BASE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  input  logic [7:0] mem_rdata,
  output logic [7:0] sp_out,
  output logic       mem_wr,
  output logic       sel_sp,
  output logic       sel_rn,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_is_ret,
  output logic       sp_empty,
  output logic       ovf_err,
  output logic       unf_err
);

  stack_state_e state_q;
  stack_state_e state_d;
  stack_op_e    op;
  logic [7:0]   sp_q;
  logic         ret_q;
  logic         accept;
  logic         is_wr_op;
  logic         is_rd_op;
  logic         push_ok;
  logic         pop_ok;
  logic         push_go;
  logic         pop_go;

  assign op        = stack_op_e'(req_op);
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign is_wr_op  = (op == OP_PUSH) || (op == OP_CALL);
  assign is_rd_op  = (op == OP_POP)  || (op == OP_RET);

`ifdef STACK_GUARD_EN
  assign push_ok = (sp_q >= STACK_LIMIT);
  assign pop_ok  = (sp_q != STACK_BASE);
`else
  assign push_ok = 1'b1;
  assign pop_ok  = 1'b1;
`endif

  // A refused request is still consumed; it just does not move SP or write.
  assign push_go = accept && is_wr_op && push_ok;
  assign pop_go  = accept && is_rd_op && pop_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pop_go) state_d = ST_POP_RD;
      ST_POP_RD: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Memory steering; all zero when no stack op is active so R0 addressing
  // is the default.
  always_comb begin
    mem_wr = push_go;
    sel_sp = push_go || (state_q == ST_POP_RD);
    sel_rn = push_go && (op == OP_PUSH);
  end

  // SP and response datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q       <= STACK_BASE;
      ret_q      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_is_ret <= 1'b0;
    end else begin
      rsp_valid <= (state_q == ST_POP_RD);
      if (push_go) begin
        sp_q <= sp_q - 8'd1;
      end else if (pop_go) begin
        sp_q  <= sp_q + 8'd1;
        ret_q <= (op == OP_RET);
      end
      if (state_q == ST_POP_RD) begin
        rsp_data   <= mem_rdata;
        rsp_is_ret <= ret_q;
      end
    end
  end

`ifdef STACK_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (accept && is_wr_op && !push_ok) ovf_err <= 1'b1;
      if (accept && is_rd_op && !pop_ok)  unf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
  assign unf_err = 1'b0;
`endif

  assign sp_out   = sp_q;
  assign sp_empty = (sp_q == STACK_BASE);

endmodule
